pipelined_control: RTL

- Registered, stall-aware successor to the combinational MIPS decoder; sits between the IF/ID latch and the ID/EX latch.
- Decodes one instruction per cycle into EX/MEM/WB control bundles and branch/jump controls.
- Adds multi-cycle DIV sequencing, a SYSCALL request/acknowledge handshake, bubble insertion on stall/flush, and a sticky HALT on BREAK (no simulator $finish).

---
 rtl/pipelined_control_if.sv | 47 ++++
 rtl/pipelined_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_if.sv
// ---------------------------------------------------------------------------
// pipelined_control_if
// Bundles the decode-stage signals between IF/ID, the pipelined control unit
// and the ID/EX latch.
//   Upstream -> control : instr, instr_valid, stall_in, flush_in, syscall_ack
//   Control -> ID/EX     : ex_ctrl {RegDst, ALUsrc, ALUop}, mem_ctrl
//                          {MemWrite, MemRead}, wb_ctrl {RegWrite, MemToReg},
//                          jump, branch, jr_ctrl, jal_ctrl, branch_op,
//                          ctrl_valid
//   Control -> upstream  : stall_out, syscall_req, illegal, halted
// modport master: the side that feeds instructions and consumes the bundles.
// modport slave : the control unit itself.
// ---------------------------------------------------------------------------
interface pipelined_control_if #(
    parameter int ALUOP_W = 5
);
    logic [31:0]        instr;
    logic               instr_valid;
    logic               stall_in;
    logic               flush_in;
    logic               syscall_ack;
    logic [ALUOP_W+1:0] ex_ctrl;
    logic [1:0]         mem_ctrl;
    logic [1:0]         wb_ctrl;
    logic               jump;
    logic               branch;
    logic               jr_ctrl;
    logic               jal_ctrl;
    logic [2:0]         branch_op;
    logic               ctrl_valid;
    logic               stall_out;
    logic               syscall_req;
    logic               illegal;
    logic               halted;

    modport master (
        output instr, instr_valid, stall_in, flush_in, syscall_ack,
        input  ex_ctrl, mem_ctrl, wb_ctrl, jump, branch, jr_ctrl, jal_ctrl,
               branch_op, ctrl_valid, stall_out, syscall_req, illegal, halted
    );

    modport slave (
        input  instr, instr_valid, stall_in, flush_in, syscall_ack,
        output ex_ctrl, mem_ctrl, wb_ctrl, jump, branch, jr_ctrl, jal_ctrl,
               branch_op, ctrl_valid, stall_out, syscall_req, illegal, halted
    );
endinterface

// File: rtl/pipelined_control.sv
// ---------------------------------------------------------------------------
// pipelined_control
// Registered, stall-aware MIPS control decoder between IF/ID and ID/EX.
// Decodes one instruction per cycle into EX/MEM/WB control bundles plus
// branch/jump controls, with one cycle of latency. Sequences multi-cycle DIV,
// holds a SYSCALL request until acknowledged, inserts bubbles on stall/flush
// and parks in a sticky HALT state after BREAK.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : pipelined_control_if.slave (see interface header for members)
// ---------------------------------------------------------------------------
module pipelined_control #(
    parameter int ALUOP_W    = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_control_if.slave    bus
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_LUI  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_MFLO = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_MFHI = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] OP_MOVZ = ALUOP_W'(13);

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic               mem_to_reg;
        logic               jump;
        logic               branch;
        logic               jr;
        logic               jal;
        logic [2:0]         branch_op;
    } bundle_t;

    typedef enum logic [1:0] {RUN, DIV_WAIT, SYS_WAIT, HALT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    bundle_t            bundle_reg, bundle_next;
    logic               valid_reg, valid_next;
    logic               stall_reg, stall_next;
    logic               sreq_reg, sreq_next;
    logic               illegal_reg, illegal_next;
    logic               halted_reg, halted_next;

    // Pure decode of the current instruction word.
    bundle_t            dec;
    logic               dec_ok;
    logic               is_div;
    logic               is_sys;
    logic               is_brk;
    logic               r_type;
    logic [ALUOP_W-1:0] r_op;

    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        is_div = 1'b0;
        is_sys = 1'b0;
        is_brk = 1'b0;
        r_type = 1'b0;
        r_op   = OP_AND;
        case (bus.instr[31:26])
            6'h00: begin
                // The all-zero word is the canonical NOP (SLL $0,$0,0) and
                // carries no control at all, unlike a real SLL.
                if (bus.instr != 32'd0) begin
                    case (bus.instr[5:0])
                        6'h00:        begin r_type = 1'b1; r_op = OP_SLL;  end
                        6'h03:        begin r_type = 1'b1; r_op = OP_SRA;  end
                        6'h08:        begin dec.jump = 1'b1; dec.jr = 1'b1; end
                        6'h0A:        begin r_type = 1'b1; r_op = OP_MOVZ; end
                        6'h0C:        begin dec.reg_write = 1'b1; is_sys = 1'b1; end
                        6'h0D:        is_brk = 1'b1;
                        6'h10:        begin r_type = 1'b1; r_op = OP_MFHI; end
                        6'h12:        begin r_type = 1'b1; r_op = OP_MFLO; end
                        6'h1A:        begin r_type = 1'b1; r_op = OP_DIV; is_div = 1'b1; end
                        6'h20, 6'h21: begin r_type = 1'b1; r_op = OP_ADD;  end
                        6'h22, 6'h23: begin r_type = 1'b1; r_op = OP_SUB;  end
                        6'h24:        begin r_type = 1'b1; r_op = OP_AND;  end
                        6'h25:        begin r_type = 1'b1; r_op = OP_OR;   end
                        6'h2A:        begin r_type = 1'b1; r_op = OP_SLT;  end
                        default:      dec_ok = 1'b0;
                    endcase
                end
            end
            // REGIMM: only BLTZ (rt == 0) is supported.
            6'h01: begin
                if (bus.instr[20:16] == 5'd0) begin
                    dec.branch    = 1'b1;
                    dec.branch_op = 3'b110;
                end else begin
                    dec_ok = 1'b0;
                end
            end
            6'h02: dec.jump = 1'b1;
            6'h03: begin dec.jump = 1'b1; dec.jal = 1'b1; dec.reg_write = 1'b1; end
            6'h04: begin dec.branch = 1'b1; dec.branch_op = 3'b001; end
            6'h05: begin dec.branch = 1'b1; dec.branch_op = 3'b100; end
            6'h08, 6'h09: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = OP_ADD; end
            6'h0C: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = OP_AND; end
            6'h0D: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = OP_OR;  end
            6'h0F: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = OP_LUI; end
            6'h23: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = OP_ADD;
            end
            6'h28, 6'h2B: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = OP_ADD; end
            default: dec_ok = 1'b0;
        endcase
        if (r_type) begin
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = r_op;
        end
    end

    // Next-state and next-output logic; every register defaults to a bubble.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bundle_next  = '0;
        valid_next   = 1'b0;
        stall_next   = 1'b0;
        sreq_next    = 1'b0;
        illegal_next = 1'b0;
        halted_next  = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.flush_in || bus.stall_in || !bus.instr_valid) begin
                    // bubble
                end else if (!dec_ok) begin
                    illegal_next = 1'b1;
                end else if (is_brk) begin
                    halted_next = 1'b1;
                    stall_next  = 1'b1;
                    state_next  = HALT;
                end else begin
                    bundle_next = dec;
                    valid_next  = 1'b1;
                    if (is_div && (DIV_CYCLES > 1)) begin
                        cnt_next   = CNT_W'(DIV_CYCLES - 1);
                        stall_next = 1'b1;
                        state_next = DIV_WAIT;
                    end else if (is_sys) begin
                        sreq_next  = 1'b1;
                        stall_next = 1'b1;
                        state_next = SYS_WAIT;
                    end
                end
            end
            DIV_WAIT: begin
                // Counter was loaded with DIV_CYCLES-1; the edge that takes it
                // to zero releases the stall, giving DIV_CYCLES-1 stall cycles.
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = RUN;
                end else begin
                    stall_next = 1'b1;
                end
            end
            SYS_WAIT: begin
                if (bus.syscall_ack) begin
                    state_next = RUN;
                end else begin
                    sreq_next  = 1'b1;
                    stall_next = 1'b1;
                end
            end
            HALT: begin
                halted_next = 1'b1;
                stall_next  = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= RUN;
            cnt_reg     <= '0;
            bundle_reg  <= '0;
            valid_reg   <= 1'b0;
            stall_reg   <= 1'b0;
            sreq_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            halted_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bundle_reg  <= bundle_next;
            valid_reg   <= valid_next;
            stall_reg   <= stall_next;
            sreq_reg    <= sreq_next;
            illegal_reg <= illegal_next;
            halted_reg  <= halted_next;
        end
    end

    assign bus.ex_ctrl     = {bundle_reg.reg_dst, bundle_reg.alu_src, bundle_reg.alu_op};
    assign bus.mem_ctrl    = {bundle_reg.mem_write, bundle_reg.mem_read};
    assign bus.wb_ctrl     = {bundle_reg.reg_write, bundle_reg.mem_to_reg};
    assign bus.jump        = bundle_reg.jump;
    assign bus.branch      = bundle_reg.branch;
    assign bus.jr_ctrl     = bundle_reg.jr;
    assign bus.jal_ctrl    = bundle_reg.jal;
    assign bus.branch_op   = bundle_reg.branch_op;
    assign bus.ctrl_valid  = valid_reg;
    assign bus.stall_out   = stall_reg;
    assign bus.syscall_req = sreq_reg;
    assign bus.illegal     = illegal_reg;
    assign bus.halted      = halted_reg;

endmodule
